shift_seq_reg: RTL

Parametrised sequenced universal shift register: holds a WIDTH-bit word and executes one command per start, either a parallel load or a multi-step shift or rotate of `amt` single-bit steps, one step per clock. It is the successor of the lab's fixed 8-bit hold/load/left/right register and adds the following:
- arbitrary width;
- arithmetic shift and rotate modes;
- serial-out bits;
- a busy/done handshake so a controller can issue N-bit shifts as single commands.

---
 rtl/shift_seq_reg_pkg.sv | 32 +++
 rtl/shift_seq_reg_step.sv | 46 ++++
 rtl/shift_seq_reg.sv | 102 ++++++++++
 3 files changed

// File: rtl/shift_seq_reg_pkg.sv
// Shared types for the sequenced universal shift register: command opcodes
// and controller states.
package shift_pkg;

    typedef enum logic [2:0] {
        OP_HOLD = 3'd0,
        OP_LOAD = 3'd1,
        OP_SHL  = 3'd2,
        OP_SHR  = 3'd3,
        OP_SAR  = 3'd4,
        OP_ROL  = 3'd5,
        OP_ROR  = 3'd6,
        OP_RSVD = 3'd7
    } op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // True for opcodes that take amt single-bit steps through the RUN state.
    function automatic logic isStepOp(input op_t o);
        logic r;
        case (o)
            OP_SHL, OP_SHR, OP_SAR, OP_ROL, OP_ROR: r = 1'b1;
            default:                                 r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/shift_seq_reg_step.sv
// One single-bit shift/rotate step: combinational next word and the bit
// that leaves the register.
module shift_step
    import shift_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] q,
    input  op_t              op,
    input  logic             sin,
    output logic [WIDTH-1:0] next_q,
    output logic             out_bit
);

    always_comb begin
        next_q  = q;
        out_bit = 1'b0;
        case (op)
            OP_SHL: begin
                next_q  = {q[WIDTH-2:0], sin};
                out_bit = q[WIDTH-1];
            end
            OP_SHR: begin
                next_q  = {sin, q[WIDTH-1:1]};
                out_bit = q[0];
            end
            OP_SAR: begin
                next_q  = {q[WIDTH-1], q[WIDTH-1:1]};
                out_bit = q[0];
            end
            OP_ROL: begin
                next_q  = {q[WIDTH-2:0], q[WIDTH-1]};
                out_bit = q[WIDTH-1];
            end
            OP_ROR: begin
                next_q  = {q[0], q[WIDTH-1:1]};
                out_bit = q[0];
            end
            default: begin
                next_q  = q;
                out_bit = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/shift_seq_reg.sv
// Sequenced universal shift register: accepts one command in IDLE, runs
// multi-step shifts one bit per clock, and pulses done when finished.
module shift_seq_reg
    import shift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic [WIDTH-1:0] d,
    input  op_t              op,
    input  logic [CNT_W-1:0] amt,
    input  logic             start,
    input  logic             sin,
    output logic [WIDTH-1:0] q,
    output logic             sout,
    output logic             busy,
    output logic             done
);

    state_t           state_q, state_d;
    op_t              op_q, op_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic             sout_q, sout_d;

    logic [WIDTH-1:0] stepWord;
    logic             stepBit;

    // The step unit always works on the latched opcode, so op changes on the
    // port during RUN cannot disturb a command in flight.
    shift_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .q       (word_q),
        .op      (op_q),
        .sin     (sin),
        .next_q  (stepWord),
        .out_bit (stepBit)
    );

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q <= IDLE;
            op_q    <= OP_HOLD;
            cnt_q   <= '0;
            word_q  <= '0;
            sout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            sout_q  <= sout_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        word_d  = word_q;
        sout_d  = sout_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (op == OP_LOAD) begin
                        word_d  = d;
                        state_d = DONE;
                    end else if (isStepOp(op) && (amt != '0)) begin
                        op_d    = op;
                        cnt_d   = amt;
                        state_d = RUN;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            RUN: begin
                word_d = stepWord;
                sout_d = stepBit;
                cnt_d  = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign q    = word_q;
    assign sout = sout_q;
    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);

endmodule
